mem_access_unit: RTL and testbench
==================================

# mem_access_unit

MEM-stage consumer of the EX/MEM pipeline register: takes the registered address, store data and MEM/WB control, performs the data-memory access over a req/ack handshake, and drives the MEM/WB register. Stalls the upstream pipeline (PC, IF/ID, ID/EX, EX/MEM) while an access is outstanding. Inserts bubbles into MEM/WB during stalls and reports misaligned and timed-out accesses.

## Interface
- TIMEOUT, 16: maximum number of BUSY cycles allowed without `mem_ack_i` before the access is aborted (≥1).
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- pc_i, ALUresult_i, RS2data_i  in  32 each  EX/MEM outputs: PC, byte address, store data.
- RDaddr_i  in  5  destination register.
- MemRead_i, MemWrite_i, MemtoReg_i  in  1 each  EX/MEM control bits.
- stall_o  out  1  freeze upstream pipeline registers (combinational).
- mem_req_o, mem_we_o  out  1 each  memory request; write when high (registered).
- mem_addr_o, mem_wdata_o  out  32 each  latched address and store data (registered).
- mem_ack_i  in  1  memory completes the request this cycle.
- mem_rdata_i  in  32  load data, valid when `mem_ack_i`=1.
- pc_o, ALUresult_o, ReadData_o  out  32 each  MEM/WB register outputs.
- RDaddr_o  out  5, MemtoReg_o  out  1  MEM/WB register outputs.
- err_o  out  1  one-cycle pulse: misaligned or timed-out access.

## Operation
- States: IDLE, BUSY, DONE. Access request `acc` = (MemRead_i | MemWrite_i) in IDLE.
- IDLE, no `acc`: MEM/WB loads {pc_i, ALUresult_i, ReadData=0, RDaddr_i, MemtoReg_i}; stall_o=0.
- IDLE, `acc`, ALUresult_i[1:0]≠0: no memory access, no stall; MEM/WB loads the instruction with RDaddr_o=0, MemtoReg_o=0; err_o=1 next cycle.
- IDLE, `acc`, aligned: stall_o=1; at edge latch mem_addr_o=ALUresult_i, mem_wdata_o=RS2data_i, mem_we_o=MemWrite_i; mem_req_o←1; go BUSY; MEM/WB loads bubble (RDaddr_o=0, MemtoReg_o=0, ReadData_o=0, others 0).
- MemRead_i and MemWrite_i both 1: treated as write; ReadData 0.
- BUSY: stall_o=1; mem_req_o, address, data, we held stable; MEM/WB loads bubble each cycle. On edge with mem_ack_i=1: capture mem_rdata_i (loads only; stores capture 0), mem_req_o←0, go DONE. Timeout counter counts BUSY cycles; at TIMEOUT cycles without ack: mem_req_o←0, captured data=0, err_o pulse, go DONE with RDaddr forced 0.
- DONE: stall_o=0; at edge MEM/WB loads {pc_i, ALUresult_i, captured data, RDaddr_i (0 on timeout), MemtoReg_i}; go IDLE. No new access starts in DONE (EX/MEM still shows the same instruction this cycle).
- mem_ack_i outside BUSY is ignored.

## Timing
- Non-memory instruction: MEM/WB updated one edge after EX/MEM, zero stall.
- Memory access: stall_o high for 1 + N cycles (IDLE detect cycle + N BUSY cycles, N≥1); ack in first BUSY cycle gives 2 stall cycles; result in MEM/WB at end of DONE.
- Timeout: N = TIMEOUT; err_o high during the DONE cycle.
- Reset values: state IDLE, timeout counter 0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, all MEM/WB outputs 0, err_o=0. stall_o=0 while rst_i=1.
- Reset during BUSY: mem_req_o drops after the reset edge; outstanding request is abandoned; a late ack is ignored.
- Timeout counter width $clog2(TIMEOUT+1); cleared on entry to BUSY.

## Structure
- Package `mem_stage_pkg`: state enum {IDLE, BUSY, DONE}, BUBBLE_RD=5'd0, width constants (XLEN=32, REG_AW=5).
- One sub-module: `mem_wb_reg`, the MEM/WB output register with load and bubble inputs; FSM, handshake and timeout live in the top.

## Test plan
- ALU op, ALUresult_i=0x10, RDaddr_i=5, no Mem bits -> next edge ALUresult_o=0x10, RDaddr_o=5, stall_o never high.
- Load addr 0x20, memory acks in first BUSY cycle with 0xDEADBEEF -> stall_o high 2 cycles, mem_we_o=0, then ReadData_o=0xDEADBEEF, MemtoReg_o=1, RDaddr_o correct; bubbles (RDaddr_o=0) during stall.
- Store addr 0x40 data 0x12345678, ack after 3 cycles -> mem_we_o=1, mem_wdata_o=0x12345678 stable 3 cycles, stall_o high 4 cycles.
- Load addr 0x22 -> no mem_req_o, no stall, err_o pulse, RDaddr_o=0.
- Load with ack never asserted, TIMEOUT=4 -> mem_req_o high 4 cycles, err_o pulse, ReadData_o=0, RDaddr_o=0, pipeline resumes.
- rst_i asserted in BUSY then ack arrives -> mem_req_o=0 after edge, all outputs 0, ack ignored, state IDLE.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and widths for the MEM stage: FSM state encoding and the MEM/WB record.
package mem_stage_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] BUBBLE_RD = 5'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   alu;
    logic [XLEN-1:0]   rdata;
    logic [REG_AW-1:0] rd;
    logic              m2r;
  } mem_wb_t;
endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; a bubble clears every field so nothing retires.
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    load,
  input  logic    bubble,
  input  mem_wb_t d,
  output mem_wb_t q
);
  always_ff @(posedge clk_i) begin
    if (rst_i)     q <= '0;
    else if (load) q <= bubble ? mem_wb_t'('0) : d;
  end
endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: drives one data-memory access per load/store over req/ack, stalls
// upstream while it is outstanding, and feeds MEM/WB with results or bubbles.
module mem_access_unit
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   ALUresult_i,
  input  logic [XLEN-1:0]   RS2data_i,
  input  logic [REG_AW-1:0] RDaddr_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              MemtoReg_i,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic [XLEN-1:0]   pc_o,
  output logic [XLEN-1:0]   ALUresult_o,
  output logic [XLEN-1:0]   ReadData_o,
  output logic [REG_AW-1:0] RDaddr_o,
  output logic              MemtoReg_o,
  output logic              err_o
);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_e          state;
  logic [CW-1:0]   cnt;
  logic            timed_out;
  logic [XLEN-1:0] rdata_q;
  logic            acc, misal, start, bubble, wb_load;
  mem_wb_t         wb_d, wb_q;

  assign acc     = MemRead_i | MemWrite_i;
  assign misal   = |ALUresult_i[1:0];
  assign start   = (state == IDLE) && acc && !misal;
  assign bubble  = start || (state == BUSY);
  assign wb_load = 1'b1;
  assign stall_o = !rst_i && bubble;

  always_comb begin
    wb_d = '{pc: pc_i, alu: ALUresult_i, rdata: '0, rd: RDaddr_i, m2r: MemtoReg_i};
    // A rejected misaligned access still retires, but must not write back.
    if (state == IDLE && acc && misal) begin
      wb_d.rd  = BUBBLE_RD;
      wb_d.m2r = 1'b0;
    end
    if (state == DONE) begin
      wb_d.rdata = rdata_q;
      if (timed_out) wb_d.rd = BUBBLE_RD;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      timed_out   <= 1'b0;
      rdata_q     <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      err_o       <= 1'b0;
    end else begin
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (acc) begin
            if (misal) begin
              err_o <= 1'b1;
            end else begin
              mem_addr_o  <= ALUresult_i;
              mem_wdata_o <= RS2data_i;
              mem_we_o    <= MemWrite_i;
              mem_req_o   <= 1'b1;
              cnt         <= '0;
              timed_out   <= 1'b0;
              state       <= BUSY;
            end
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            rdata_q   <= mem_we_o ? '0 : mem_rdata_i;
            mem_req_o <= 1'b0;
            state     <= DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th BUSY cycle with no ack: abandon it.
            rdata_q   <= '0;
            mem_req_o <= 1'b0;
            timed_out <= 1'b1;
            err_o     <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  mem_wb_reg u_mem_wb (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load   (wb_load),
    .bubble (bubble),
    .d      (wb_d),
    .q      (wb_q)
  );

  assign pc_o        = wb_q.pc;
  assign ALUresult_o = wb_q.alu;
  assign ReadData_o  = wb_q.rdata;
  assign RDaddr_o    = wb_q.rd;
  assign MemtoReg_o  = wb_q.m2r;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, hand-built reset sequences,
// and randomized instructions checked against a per-instruction timing model.
module tb_mem_access_unit;
  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_i, ALUresult_i, RS2data_i, mem_rdata_i;
  logic [4:0]  RDaddr_i;
  logic        MemRead_i, MemWrite_i, MemtoReg_i, mem_ack_i;
  logic        stall_o, mem_req_o, mem_we_o, MemtoReg_o, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, pc_o, ALUresult_o, ReadData_o;
  logic [4:0]  RDaddr_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc, alu, rs2, rdata;
    logic [4:0]  rd;
    logic        mr, mw, m2r;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    logic        exp_m2r, exp_err;
    int          exp_stall;
  } vec_t;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .ALUresult_i(ALUresult_i),
    .RS2data_i(RS2data_i), .RDaddr_i(RDaddr_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .MemtoReg_i(MemtoReg_i), .stall_o(stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .pc_o(pc_o), .ALUresult_o(ALUresult_o), .ReadData_o(ReadData_o),
    .RDaddr_o(RDaddr_o), .MemtoReg_o(MemtoReg_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic chk_wb(input string tag, input logic [31:0] pc, input logic [31:0] alu,
                        input logic [31:0] data, input logic [4:0] rd, input logic m2r);
    chk({tag, ".pc"},    pc_o,             pc);
    chk({tag, ".alu"},   ALUresult_o,      alu);
    chk({tag, ".rdata"}, ReadData_o,       data);
    chk({tag, ".rd"},    32'(RDaddr_o),    32'(rd));
    chk({tag, ".m2r"},   32'(MemtoReg_o),  32'(m2r));
  endtask

  task automatic drive(input vec_t v);
    pc_i = v.pc; ALUresult_i = v.alu; RS2data_i = v.rs2; RDaddr_i = v.rd;
    MemRead_i = v.mr; MemWrite_i = v.mw; MemtoReg_i = v.m2r;
  endtask

  // Upstream holds the instruction while stalled; memory acks on the last BUSY cycle
  // implied by exp_stall (never, for a timeout). Stray acks outside BUSY are injected.
  task automatic run(input string tag, input vec_t v);
    int   n;
    logic tout;
    n    = (v.exp_stall > 0) ? v.exp_stall - 1 : 0;
    tout = v.exp_err && (v.exp_stall > 0);
    drive(v);
    mem_ack_i = 1'($urandom); mem_rdata_i = $urandom;
    #1 chk({tag, ".stall0"}, 32'(stall_o), 32'(v.exp_stall > 0));
    @(posedge clk_i); #1;
    if (v.exp_stall == 0) begin
      chk_wb({tag, ".wb"}, v.pc, v.alu, v.exp_data, v.exp_rd, v.exp_m2r);
      chk({tag, ".err"}, 32'(err_o), 32'(v.exp_err));
      chk({tag, ".req"}, 32'(mem_req_o), 32'd0);
      return;
    end
    chk({tag, ".req"},   32'(mem_req_o), 32'd1);
    chk({tag, ".we"},    32'(mem_we_o),  32'(v.mw));
    chk({tag, ".addr"},  mem_addr_o,     v.alu);
    chk({tag, ".wdata"}, mem_wdata_o,    v.rs2);
    chk_wb({tag, ".bub"}, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    for (int k = 1; k <= n; k++) begin
      mem_ack_i   = (k == n) && !tout;
      mem_rdata_i = mem_ack_i ? v.rdata : $urandom;
      #1 chk({tag, ".stallb"}, 32'(stall_o), 32'd1);
      @(posedge clk_i); #1;
      chk_wb({tag, ".bubk"}, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      if (k < n) begin
        chk({tag, ".reqk"},   32'(mem_req_o), 32'd1);
        chk({tag, ".addrk"},  mem_addr_o,     v.alu);
        chk({tag, ".wdatak"}, mem_wdata_o,    v.rs2);
        chk({tag, ".wek"},    32'(mem_we_o),  32'(v.mw));
      end else begin
        chk({tag, ".reqend"}, 32'(mem_req_o), 32'd0);
        chk({tag, ".errto"},  32'(err_o),     32'(tout));
      end
    end
    mem_ack_i = 1'($urandom); mem_rdata_i = $urandom;
    #1 chk({tag, ".stalld"}, 32'(stall_o), 32'd0);
    @(posedge clk_i); #1;
    chk_wb({tag, ".res"}, v.pc, v.alu, v.exp_data, v.exp_rd, v.exp_m2r);
    chk({tag, ".errd"}, 32'(err_o),     32'd0);
    chk({tag, ".reqd"}, 32'(mem_req_o), 32'd0);
  endtask

  vec_t tbl[7];
  vec_t v;
  int   lat, nb;
  logic to_hit;

  initial begin
    //       pc         alu        rs2          rdata        rd  mr mw m2r  exp_rd exp_data     m2r err stall
    tbl[0] = '{32'h100, 32'h10, 32'h0,        32'h0,        5'd5, 0, 0, 0, 5'd5, 32'h0,        0, 0, 0};
    tbl[1] = '{32'h104, 32'h20, 32'h0,        32'hDEADBEEF, 5'd9, 1, 0, 1, 5'd9, 32'hDEADBEEF, 1, 0, 2};
    tbl[2] = '{32'h108, 32'h40, 32'h12345678, 32'h55AA55AA, 5'd3, 0, 1, 0, 5'd3, 32'h0,        0, 0, 4};
    tbl[3] = '{32'h10C, 32'h22, 32'h0,        32'h0,        5'd4, 1, 0, 1, 5'd0, 32'h0,        0, 1, 0};
    tbl[4] = '{32'h110, 32'h30, 32'h0,        32'h0,        5'd6, 1, 0, 1, 5'd0, 32'h0,        1, 1, 5};
    tbl[5] = '{32'h114, 32'h44, 32'hABCD0000, 32'h77777777, 5'd8, 1, 1, 1, 5'd8, 32'h0,        1, 0, 3};
    tbl[6] = '{32'h118, 32'h4C, 32'h0,        32'h0,        5'd2, 0, 1, 0, 5'd0, 32'h0,        0, 1, 5};

    rst_i = 1'b1; mem_ack_i = 1'b0; mem_rdata_i = '0;
    v = '{32'h0, 32'h20, 32'h0, 32'h0, 5'd1, 1, 0, 0, 5'd0, 32'h0, 0, 0, 0};
    drive(v);
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst.stall", 32'(stall_o), 32'd0);
    chk("rst.req",   32'(mem_req_o), 32'd0);
    chk("rst.we",    32'(mem_we_o), 32'd0);
    chk("rst.addr",  mem_addr_o, 32'd0);
    chk("rst.wdata", mem_wdata_o, 32'd0);
    chk("rst.err",   32'(err_o), 32'd0);
    chk_wb("rst", 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    rst_i = 1'b0;

    for (int i = 0; i < 7; i++) run($sformatf("vec%0d", i), tbl[i]);

    // Reset while BUSY, then a late ack that must be ignored.
    v = '{32'h200, 32'h80, 32'h0, 32'h0, 5'd7, 1, 0, 1, 5'd0, 32'h0, 0, 0, 0};
    drive(v); mem_ack_i = 1'b0;
    @(posedge clk_i); #1;
    chk("rb.req", 32'(mem_req_o), 32'd1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk("rb.req0",  32'(mem_req_o), 32'd0);
    chk("rb.addr0", mem_addr_o, 32'd0);
    chk("rb.err0",  32'(err_o), 32'd0);
    chk("rb.stall", 32'(stall_o), 32'd0);
    chk_wb("rb", 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    rst_i = 1'b0;
    v = '{32'h300, 32'h8, 32'h0, 32'h0, 5'd7, 0, 0, 0, 5'd0, 32'h0, 0, 0, 0};
    drive(v); mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
    #1 chk("late.stall", 32'(stall_o), 32'd0);
    @(posedge clk_i); #1;
    chk("late.req", 32'(mem_req_o), 32'd0);
    chk_wb("late", 32'h300, 32'h8, 32'd0, 5'd7, 1'b0);
    mem_ack_i = 1'b0;

    // Randomized instructions; expectations come from the instruction-level model.
    for (int i = 0; i < 60; i++) begin
      v.pc  = $urandom; v.rs2 = $urandom; v.rdata = $urandom;
      v.rd  = 5'($urandom); v.mr = 1'($urandom); v.mw = 1'($urandom); v.m2r = 1'($urandom);
      v.alu = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 4) == 0) v.alu = v.alu + 32'($urandom_range(1, 3));
      lat = $urandom_range(1, 6);
      if (!(v.mr || v.mw)) begin
        v.exp_rd = v.rd; v.exp_data = 0; v.exp_m2r = v.m2r; v.exp_err = 0; v.exp_stall = 0;
      end else if (v.alu % 4 != 0) begin
        v.exp_rd = 0; v.exp_data = 0; v.exp_m2r = 0; v.exp_err = 1; v.exp_stall = 0;
      end else begin
        to_hit      = lat > TO;
        nb          = to_hit ? TO : lat;
        v.exp_stall = 1 + nb;
        v.exp_err   = to_hit;
        v.exp_rd    = to_hit ? 5'd0 : v.rd;
        v.exp_data  = (to_hit || v.mw) ? 32'd0 : v.rdata;
        v.exp_m2r   = v.m2r;
      end
      run($sformatf("rnd%0d", i), v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
